// File: rtl/fetch_queue_unit_if.sv
// Bus bundle for the fetch queue: instruction-memory port, redirect input and decode handshake.
interface fetch_queue_unit_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int IMEM_AW = 11
);
    logic                   imem_req_o;
    logic [IMEM_AW-1:0]     imem_addr_o;
    logic [31:0]            imem_rdata_i;
    logic                   redirect_i;
    logic [XLEN-1:0]        redirect_pc_i;
    logic                   inst_valid_o;
    logic [31:0]            inst_o;
    logic [XLEN-1:0]        inst_pc_o;
    logic                   inst_ready_i;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, fetches from a 1-cycle synchronous imem
// and buffers {pc, inst} pairs in a circular queue feeding decode.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              IMEM_AW  = 11,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_queue_unit_if.master fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_fetchPc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflightPc;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_pcMem   [DEPTH];
    logic [31:0]     r_instMem [DEPTH];

    logic [CW:0]     w_pending;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    // A request is only issued when the queue has room for it plus the one already in flight.
    assign w_valid   = (r_count != '0);
    assign w_pending = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue   = reset_n && !fq.redirect_i && (w_pending < (CW+1)'(DEPTH));
    assign w_push    = r_inflight && !fq.redirect_i;
    assign w_pop     = w_valid && fq.inst_ready_i;

    assign fq.imem_req_o   = w_issue;
    assign fq.imem_addr_o  = {r_fetchPc[IMEM_AW-1:2], 2'b00};
    assign fq.inst_valid_o = w_valid;
    assign fq.inst_o       = w_valid ? r_instMem[r_rdPtr] : '0;
    assign fq.inst_pc_o    = w_valid ? r_pcMem[r_rdPtr] : '0;
    assign fq.count_o      = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetchPc    <= RESET_PC;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
        end else if (fq.redirect_i) begin
            // A redirect squashes the queue and the in-flight response in one step.
            r_fetchPc    <= fq.redirect_pc_i & ~XLEN'(3);
            r_inflight   <= 1'b0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
        end else begin
            if (w_issue) begin
                r_inflight   <= 1'b1;
                r_inflightPc <= r_fetchPc;
                r_fetchPc    <= r_fetchPc + XLEN'(4);
            end else begin
                r_inflight   <= 1'b0;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]   <= r_inflightPc;
            r_instMem[r_wrPtr] <= fq.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: vector table, directed redirect/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_queue_unit;
    localparam int          XLEN    = 32;
    localparam int          DEPTH   = 4;
    localparam int          IMEM_AW = 11;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW)) bus();
    fetch_queue_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW)) wrapBus();

    fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .fq(bus.master));

    fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(WRAP_PC)) wrapDut (
        .clk(clk), .reset_n(reset_n), .fq(wrapBus.master));

    function automatic logic [31:0] instOf(input logic [IMEM_AW-1:0] addr);
        return {addr, 21'h0} ^ 32'h0000_0013;
    endfunction

    // Synchronous-read instruction memories with one cycle of latency.
    always @(posedge clk) begin
        bus.imem_rdata_i     <= instOf(bus.imem_addr_o);
        wrapBus.imem_rdata_i <= instOf(wrapBus.imem_addr_o);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redirect, input logic [31:0] rpc);
        bus.inst_ready_i  = ready;
        bus.redirect_i    = redirect;
        bus.redirect_pc_i = rpc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the async clear, then releases so cycle 0 starts.
    task automatic resetDut(input string tag);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput({tag, ".rst.req"},   32'(bus.imem_req_o),   32'h0);
        checkOutput({tag, ".rst.valid"}, 32'(bus.inst_valid_o), 32'h0);
        checkOutput({tag, ".rst.inst"},  bus.inst_o,            32'h0);
        checkOutput({tag, ".rst.pc"},    bus.inst_pc_o,         32'h0);
        checkOutput({tag, ".rst.count"}, 32'(bus.count_o),      32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic checkHead(input string tag, input logic valid, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, 32'(bus.inst_valid_o), 32'(valid));
        checkOutput({tag, ".pc"},    bus.inst_pc_o,         valid ? pc : 32'h0);
        checkOutput({tag, ".inst"},  bus.inst_o,            valid ? instOf(pc[IMEM_AW-1:0]) : 32'h0);
    endtask

    typedef struct packed {
        bit          startReset;
        logic        ready;
        logic [31:0] expAddr;
        logic        expReq;
        logic        expValid;
        logic [31:0] expPc;
        logic [2:0]  expCount;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        wrapBus.inst_ready_i  = 1'b1;
        wrapBus.redirect_i    = 1'b0;
        wrapBus.redirect_pc_i = 32'h0;

        // Startup with ready high, then backpressure from reset followed by release.
        vecs.push_back('{1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 3'd0});
        vecs.push_back('{1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 32'h00, 3'd0});
        vecs.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 32'h00, 3'd1});
        vecs.push_back('{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h04, 3'd1});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h08, 3'd1});
        vecs.push_back('{1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h0C, 3'd1});
        vecs.push_back('{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 32'h00, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h08, 1'b1, 1'b1, 32'h00, 3'd1});
        vecs.push_back('{1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h00, 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h00, 3'd3});
        vecs.push_back('{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h00, 3'd4});
        vecs.push_back('{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h00, 3'd4});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h00, 3'd4});
        vecs.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h04, 3'd3});
        vecs.push_back('{1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h08, 3'd2});
        vecs.push_back('{1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 32'h0C, 3'd2});
        vecs.push_back('{1'b0, 1'b1, 32'h1C, 1'b1, 1'b1, 32'h10, 3'd2});
        vecs.push_back('{1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h14, 3'd2});

        foreach (vecs[i]) begin
            if (vecs[i].startReset) resetDut($sformatf("vec%0d", i));
            else nextCycle();
            applyStimulus(vecs[i].ready, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.req", i),   32'(bus.imem_req_o),  32'(vecs[i].expReq));
            checkOutput($sformatf("vec%0d.addr", i),  32'(bus.imem_addr_o), vecs[i].expAddr);
            checkOutput($sformatf("vec%0d.count", i), 32'(bus.count_o),     32'(vecs[i].expCount));
            checkHead($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc);
        end

        // Flush with three queued entries and one in flight.
        resetDut("flush");
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (4) nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("flush.countBefore", 32'(bus.count_o), 32'h3);
        checkOutput("flush.reqInRedirect", 32'(bus.imem_req_o), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("flush.countAfter", 32'(bus.count_o), 32'h0);
        checkOutput("flush.addr", 32'(bus.imem_addr_o), 32'h100);
        checkOutput("flush.req", 32'(bus.imem_req_o), 32'h1);
        checkHead("flush.n1", 1'b0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkHead("flush.n2", 1'b0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkHead("flush.n3", 1'b1, 32'h100);
        nextCycle();
        @(negedge clk);
        checkHead("flush.n4", 1'b1, 32'h104);

        // Redirect coinciding with a pop and a push; target is misaligned.
        resetDut("rpp");
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (4) nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h203);
        @(negedge clk);
        checkHead("rpp.popInRedirect", 1'b1, 32'h8);
        checkOutput("rpp.reqInRedirect", 32'(bus.imem_req_o), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rpp.count", 32'(bus.count_o), 32'h0);
        checkOutput("rpp.addr", 32'(bus.imem_addr_o), 32'h200);
        checkHead("rpp.n1", 1'b0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkHead("rpp.n2", 1'b0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkHead("rpp.n3", 1'b1, 32'h200);
        nextCycle();
        @(negedge clk);
        checkHead("rpp.n4", 1'b1, 32'h204);

        // Mid-operation reset with two entries queued.
        resetDut("mid");
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("mid.countBefore", 32'(bus.count_o), 32'h2);
        resetDut("mid");
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("mid.restartAddr", 32'(bus.imem_addr_o), 32'h0);
        checkOutput("mid.restartReq", 32'(bus.imem_req_o), 32'h1);
        repeat (2) nextCycle();
        @(negedge clk);
        checkHead("mid.restart", 1'b1, 32'h0);

        // PC wrap on the instance that resets to the top of the address space.
        resetDut("wrap");
        @(negedge clk);
        checkOutput("wrap.addr0", 32'(wrapBus.imem_addr_o), 32'h7F8);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] expPc;
            expPc = WRAP_PC + 32'(4 * k);
            nextCycle();
            if (k == 0) nextCycle();
            @(negedge clk);
            checkOutput($sformatf("wrap.valid%0d", k), 32'(wrapBus.inst_valid_o), 32'h1);
            checkOutput($sformatf("wrap.pc%0d", k), wrapBus.inst_pc_o, expPc);
            checkOutput($sformatf("wrap.inst%0d", k), wrapBus.inst_o, instOf(expPc[IMEM_AW-1:0]));
        end

        // Randomized run against a queue-of-PCs reference model.
        begin
            logic [31:0] mq[$];
            logic [31:0] mFetchPc;
            logic [31:0] mInflightPc;
            int          mInflight;
            resetDut("rand");
            mq.delete();
            mFetchPc    = 32'h0;
            mInflightPc = 32'h0;
            mInflight   = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        rdy;
                logic        redir;
                logic [31:0] rpc;
                logic        expIssue;
                int          occ;
                rdy   = ($urandom_range(0, 99) < (((cyc / 150) % 2) ? 30 : 90));
                redir = ($urandom_range(0, 99) < 6);
                rpc   = $urandom();
                applyStimulus(rdy, redir, rpc);
                @(negedge clk);
                occ      = mq.size();
                expIssue = !redir && (occ + mInflight < DEPTH);
                checkOutput("rand.req", 32'(bus.imem_req_o), 32'(expIssue));
                checkOutput("rand.addr", 32'(bus.imem_addr_o), {21'h0, mFetchPc[IMEM_AW-1:2], 2'b00});
                checkOutput("rand.count", 32'(bus.count_o), 32'(occ));
                checkHead("rand", occ != 0, (occ != 0) ? mq[0] : 32'h0);
                if (occ != 0 && rdy) void'(mq.pop_front());
                if (redir) begin
                    mq.delete();
                    mInflight = 0;
                    mFetchPc  = {rpc[31:2], 2'b00};
                end else begin
                    if (mInflight != 0) mq.push_back(mInflightPc);
                    if (expIssue) begin
                        mInflight   = 1;
                        mInflightPc = mFetchPc;
                        mFetchPc    = mFetchPc + 32'd4;
                    end else begin
                        mInflight = 0;
                    end
                end
                nextCycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end for the multi-cycle/pipelined successor of the single-cycle RV32 datapath. Owns the program counter, issues word fetches to a synchronous-read instruction memory (1-cycle latency), buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard any in-flight fetch.

## Interface
- XLEN, 32, PC and address width in bits
- DEPTH, 4, queue entries; power of two, ≥ 2
- IMEM_AW, 11, instruction-memory byte-address width
- RESET_PC, 0, PC fetched first after reset (word aligned)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request this cycle; always accepted
- imem_addr_o  out  IMEM_AW  byte address, fetch_pc[IMEM_AW-1:0]; bits [1:0] always 0
- imem_rdata_i  in  32  instruction for the request issued in the previous cycle
- redirect_i  in  1  taken branch/jump; flush and restart
- redirect_pc_i  in  XLEN  new fetch target
- inst_valid_o  out  1  queue head valid
- inst_o  out  32  head instruction; 0 when inst_valid_o=0
- inst_pc_o  out  XLEN  head PC; 0 when inst_valid_o=0
- inst_ready_i  in  1  decode accepts head
- count_o  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- State: fetch_pc, inflight bit plus inflight_pc, circular FIFO (wr_ptr, rd_ptr, count) of {pc, inst}.
- Issue: imem_req_o = !redirect_i && (count + inflight < DEPTH). The credit check ignores a same-cycle pop. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4, mod 2^XLEN (wraps to 0). With no issue: inflight<=0.
- Response: when inflight=1 and no redirect, {inflight_pc, imem_rdata_i} is written at wr_ptr and wr_ptr increments mod DEPTH. The credit rule guarantees the write never overflows.
- Pop: inst_valid_o && inst_ready_i advances rd_ptr. Simultaneous push and pop leaves count unchanged.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - count, wr_ptr and rd_ptr <= 0.
  - inflight <= 0, and any response arriving in the next cycle is dropped.
  - No request is issued in the redirect cycle.
  - A head handshaken in the redirect cycle counts as delivered. Decode is responsible for squashing it.
- Ordering: instructions leave in fetch order with no loss or duplication between redirects.

## Timing
- Reset (async assert) values:
  - fetch_pc = RESET_PC.
  - inflight = 0, count = 0, pointers = 0.
  - imem_req_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, count_o = 0.
- First request is issued in the first cycle after reset_n deasserts (cycle 0).
- The response to a cycle-0 request is enqueued at the end of cycle 1, and inst_valid_o is high in cycle 2. Fetch-to-valid latency is 2 cycles.
- Redirect in cycle N: request to the target in N+1, data enqueued at the end of N+2, first valid head in N+3.
- Steady state with inst_ready_i=1: one instruction per cycle.
- inst_valid_o, inst_o, inst_pc_o and count_o are driven from registers only, with no combinational path from imem_rdata_i or inst_ready_i.
- imem_req_o depends combinationally on redirect_i.
- reset_n asserted mid-operation clears all state immediately. Queued and in-flight data is lost.

## Test plan
- Startup: RESET_PC=0, imem always returns 0x00000013, ready=1 -> imem_addr_o 0x0,0x4,0x8… every cycle; inst_valid_o first high 2 cycles after reset release; inst_pc_o 0,4,8 on consecutive cycles.
- Backpressure: ready=0 from reset, DEPTH=4 -> exactly 4 requests issued, imem_req_o then held low, count_o=4. Raising ready -> PCs 0,4,8,12 delivered in order and fetching resumes at 0x10.
- Flush with in-flight: 3 entries queued plus 1 in flight, pulse redirect_i with redirect_pc_i=0x100 -> next cycle count_o=0, inst_valid_o=0, imem_addr_o=0x100. The stale response is never output, and the first valid inst_pc_o=0x100 arrives 3 cycles after the redirect.
- Redirect coinciding with a pop and a push -> queue empty afterwards, no entry from before the redirect appears later.
- Alignment/wrap: redirect_pc_i=0x203 -> fetch 0x200. RESET_PC=0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Mid-operation reset: assert reset_n=0 asynchronously with 2 entries queued -> all outputs 0 immediately. After release, fetch restarts at RESET_PC.
